// File: rtl/id_stage_if.sv
// id_stage_if: fetch-side and execute-side signals of the decode stage,
// plus the register file read ports.
//   master : driven by the surrounding pipeline (fetch, register file, execute)
//   slave  : the id_stage itself
// Signals: if_valid/if_insn/id_ready (fetch handshake), rd_addr_*/rd_data_*
// (register file reads), flush (taken branch), ex_ready/ex_valid and ex_*
// payload (ID/EX register towards execute).
interface id_stage_if #(
  parameter int WORD   = 32,
  parameter int ADDR_W = 5
);
  logic              if_valid;
  logic [WORD-1:0]   if_insn;
  logic              id_ready;
  logic [ADDR_W-1:0] rd_addr_0;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [WORD-1:0]   rd_data_0;
  logic [WORD-1:0]   rd_data_1;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [2:0]        ex_op;
  logic [WORD-1:0]   ex_opnd0;
  logic [WORD-1:0]   ex_opnd1;
  logic [WORD-1:0]   ex_imm;
  logic [5:0]        ex_funct;
  logic [ADDR_W-1:0] ex_dst;
  logic              ex_we;
  logic              ex_is_load;

  modport master (
    output if_valid, if_insn, rd_data_0, rd_data_1, flush, ex_ready,
    input  id_ready, rd_addr_0, rd_addr_1, ex_valid, ex_op, ex_opnd0,
           ex_opnd1, ex_imm, ex_funct, ex_dst, ex_we, ex_is_load
  );

  modport slave (
    input  if_valid, if_insn, rd_data_0, rd_data_1, flush, ex_ready,
    output id_ready, rd_addr_0, rd_addr_1, ex_valid, ex_op, ex_opnd0,
           ex_opnd1, ex_imm, ex_funct, ex_dst, ex_we, ex_is_load
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction decode stage. Decodes if_insn, drives the register
// file read addresses, and captures operands/immediate/control into the
// ID/EX register with valid/ready handshakes on both sides.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : id_stage_if.slave (fetch handshake, register file reads, flush,
//          ID/EX payload and handshake)
// A load in EX whose destination matches a used source of the incoming
// instruction forces one bubble; flush clears the ID/EX register and drops
// the current fetch.
module id_stage #(
  parameter int WORD   = 32,
  parameter int ADDR_W = 5
) (
  input logic      clk,
  input logic      rst,
  id_stage_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ALU_RR = 3'd0,
    OP_ALU_RI = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BEQ    = 3'd4,
    OP_NOP    = 3'd7
  } op_e;

  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rs0;
  logic [ADDR_W-1:0] rs1;
  op_e               dec_op;
  logic [ADDR_W-1:0] dec_dst;
  logic              dec_we;
  logic              dec_is_load;
  logic              use0;
  logic              use1;
  logic [WORD-1:0]   dec_imm;
  logic              load_en;
  logic              hazard;

  assign opcode        = bus.if_insn[31:26];
  assign rs0           = bus.if_insn[25:21];
  assign rs1           = bus.if_insn[20:16];
  assign bus.rd_addr_0 = rs0;
  assign bus.rd_addr_1 = rs1;
  assign dec_imm       = {{(WORD-16){bus.if_insn[15]}}, bus.if_insn[15:0]};

  always_comb begin
    dec_op      = OP_NOP;
    dec_dst     = '0;
    dec_we      = 1'b0;
    dec_is_load = 1'b0;
    use0        = 1'b0;
    use1        = 1'b0;
    case (opcode)
      6'h00: begin
        dec_op  = OP_ALU_RR;
        dec_dst = bus.if_insn[15:11];
        dec_we  = 1'b1;
        use0    = 1'b1;
        use1    = 1'b1;
      end
      6'h01: begin
        dec_op  = OP_ALU_RI;
        dec_dst = bus.if_insn[20:16];
        dec_we  = 1'b1;
        use0    = 1'b1;
      end
      6'h02: begin
        dec_op      = OP_LOAD;
        dec_dst     = bus.if_insn[20:16];
        dec_we      = 1'b1;
        dec_is_load = 1'b1;
        use0        = 1'b1;
      end
      6'h03: begin
        dec_op = OP_STORE;
        use0   = 1'b1;
        use1   = 1'b1;
      end
      6'h04: begin
        dec_op = OP_BEQ;
        use0   = 1'b1;
        use1   = 1'b1;
      end
      default: dec_op = OP_NOP;
    endcase
  end

  assign load_en = ~bus.ex_valid | bus.ex_ready;

  // Register 0 gets no special treatment: a load to r0 still interlocks.
  assign hazard = bus.if_valid & bus.ex_valid & bus.ex_is_load & bus.ex_we &
                  ((use0 & (bus.ex_dst == rs0)) | (use1 & (bus.ex_dst == rs1)));

  // During flush the fetch is consumed (and dropped) regardless of stalls.
  assign bus.id_ready = bus.flush | (load_en & ~hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_op      <= '0;
      bus.ex_opnd0   <= '0;
      bus.ex_opnd1   <= '0;
      bus.ex_imm     <= '0;
      bus.ex_funct   <= '0;
      bus.ex_dst     <= '0;
      bus.ex_we      <= 1'b0;
      bus.ex_is_load <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (load_en & hazard) begin
      bus.ex_valid <= 1'b0;
    end else if (load_en) begin
      bus.ex_valid   <= bus.if_valid;
      bus.ex_op      <= dec_op;
      bus.ex_opnd0   <= bus.rd_data_0;
      bus.ex_opnd1   <= bus.rd_data_1;
      bus.ex_imm     <= dec_imm;
      bus.ex_funct   <= bus.if_insn[5:0];
      bus.ex_dst     <= dec_dst;
      bus.ex_we      <= dec_we;
      bus.ex_is_load <= dec_is_load;
    end
  end

endmodule
